// File: rtl/text_vram_writer.sv
// text_vram_writer: character-stream writer that places glyph bytes into a 32-bit text VRAM and keeps a hardware cursor.
//
// Ports:
//   axi_aclk, axi_aresetn   clock and asynchronous active-low reset
//   char_valid, char_data   character handshake input; char_data[7] is the invert attribute
//   char_ready              high while idle; a character transfers on valid && ready
//   vram_we, vram_addr      one-cycle write strobe and word address
//   vram_wdata, vram_be     byte replicated into all lanes, one-hot (or full) byte enables
//   cursor_col, cursor_row  current cursor position
//   busy                    high during a glyph write or a screen clear
module text_vram_writer #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic        axi_aclk,
   input  logic        axi_aresetn,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   output logic        vram_we,
   output logic [11:0] vram_addr,
   output logic [31:0] vram_wdata,
   output logic [3:0]  vram_be,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);
   localparam int WORDS = COLS * ROWS / 4;
   localparam logic [11:0] LAST_ADDR = 12'(WORDS - 1);
   localparam logic [11:0] ROW_WORDS = 12'(COLS / 4);
   localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
   localparam logic [4:0]  ROW_MAX   = 5'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t      state_q, state_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic        we_q, we_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;

   logic [6:0]  code;
   logic        printable;
   logic [4:0]  row_inc;
   logic [11:0] cell_addr;

   assign code      = char_data[6:0];
   assign printable = (code >= 7'h20) && (code <= 7'h7E);
   // no scrolling: moving past the last row wraps back to the top
   assign row_inc   = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
   assign cell_addr = {7'd0, row_q} * ROW_WORDS + {7'd0, col_q[6:2]};

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      case (state_q)
         IDLE: begin
            if (char_valid) begin
               if (printable) begin
                  state_d = WRITE;
                  we_d    = 1'b1;
                  addr_d  = cell_addr;
                  be_d    = 4'b0001 << col_q[1:0];
                  wdata_d = {4{char_data}};
                  col_d   = (col_q == COL_MAX) ? 7'd0 : col_q + 7'd1;
                  row_d   = (col_q == COL_MAX) ? row_inc : row_q;
               end else begin
                  case (code)
                     7'h0A: begin
                        col_d = 7'd0;
                        row_d = row_inc;
                     end
                     7'h0D: col_d = 7'd0;
                     7'h08: col_d = (col_q != 7'd0) ? col_q - 7'd1 : col_q;
                     7'h0C: begin
                        state_d = CLEAR;
                        we_d    = 1'b1;
                        addr_d  = 12'd0;
                        wdata_d = 32'h0;
                        be_d    = 4'hF;
                     end
                     default: ;
                  endcase
               end
            end
         end
         WRITE: state_d = IDLE;
         CLEAR: begin
            // the strobe for addr_q is on the bus this cycle; stop after the last word
            if (addr_q == LAST_ADDR) begin
               state_d = IDLE;
               col_d   = 7'd0;
               row_d   = 5'd0;
            end else begin
               we_d   = 1'b1;
               addr_d = addr_q + 12'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q <= IDLE;
         col_q   <= 7'd0;
         row_q   <= 5'd0;
         we_q    <= 1'b0;
         addr_q  <= 12'd0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   assign char_ready = (state_q == IDLE);
   assign busy       = !char_ready;
   assign vram_we    = we_q;
   assign vram_addr  = addr_q;
   assign vram_wdata = wdata_q;
   assign vram_be    = be_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;
endmodule

// File: tb/tb_text_vram_writer.sv
// tb_text_vram_writer: scoreboard bench for text_vram_writer.
module tb_text_vram_writer;
   logic        clk = 1'b0;
   logic        axi_aresetn = 1'b0;
   logic        char_valid = 1'b0;
   logic [7:0]  char_data = 8'h00;
   logic        char_ready;
   logic        vram_we;
   logic [11:0] vram_addr;
   logic [31:0] vram_wdata;
   logic [3:0]  vram_be;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   typedef struct packed {
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  b;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int nstrobe = 0;
   int cyc = 0;
   int ecol = 0;
   int erow = 0;

   text_vram_writer dut (
      .axi_aclk(clk),
      .axi_aresetn(axi_aresetn),
      .char_valid(char_valid),
      .char_data(char_data),
      .char_ready(char_ready),
      .vram_we(vram_we),
      .vram_addr(vram_addr),
      .vram_wdata(vram_wdata),
      .vram_be(vram_be),
      .cursor_col(cursor_col),
      .cursor_row(cursor_row),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (axi_aresetn && vram_we) begin
         exp_t e;
         nstrobe++;
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL strobe_unexpected: got addr=%0d data=%h be=%b want no strobe", vram_addr, vram_wdata, vram_be);
         end else begin
            e = q.pop_front();
            if ({vram_addr, vram_wdata, vram_be} !== e) begin
               bad++;
               $display("FAIL strobe: got addr=%0d data=%h be=%b want addr=%0d data=%h be=%b",
                        vram_addr, vram_wdata, vram_be, e.a, e.d, e.b);
            end
         end
      end
   end

   // hand one character over and track the expected cursor; returns 1 time unit after the accepting edge
   task automatic send(input logic [7:0] c);
      int n;
      logic [6:0] code;
      exp_t e;
      n = 0;
      code = c[6:0];
      @(negedge clk);
      while (!char_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got char_ready=0 want 1");
      end
      char_valid = 1'b1;
      char_data = c;
      if (code >= 7'h20 && code <= 7'h7E) begin
         e.a = 12'(erow * 20 + ecol / 4);
         e.d = {4{c}};
         e.b = 4'b0001 << (ecol % 4);
         q.push_back(e);
         if (ecol == 79) begin
            ecol = 0;
            erow = (erow == 29) ? 0 : erow + 1;
         end else ecol++;
      end else if (code == 7'h0A) begin
         ecol = 0;
         erow = (erow == 29) ? 0 : erow + 1;
      end else if (code == 7'h0D) ecol = 0;
      else if (code == 7'h08) ecol = (ecol > 0) ? ecol - 1 : 0;
      @(posedge clk);
      #1 char_valid = 1'b0;
      if (code != 7'h0C) begin
         total++;
         if ({cursor_col, cursor_row} !== {7'(ecol), 5'(erow)}) begin
            bad++;
            $display("FAIL cursor(%h): got (%0d,%0d) want (%0d,%0d)", c, cursor_col, cursor_row, ecol, erow);
         end
      end
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({vram_we, vram_addr, vram_wdata, vram_be, cursor_col, cursor_row, busy, char_ready} !== {1'b0, 12'd0, 32'd0, 4'd0, 7'd0, 5'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_state: got we=%b addr=%0d data=%h be=%b cur=(%0d,%0d) busy=%b ready=%b want all zero, ready=1",
                  vram_we, vram_addr, vram_wdata, vram_be, cursor_col, cursor_row, busy, char_ready);
      end
      repeat (2) @(negedge clk);
      axi_aresetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_first_char();
      send(8'h41);
      total++;
      if ({vram_we, vram_addr, vram_be, vram_wdata, char_ready, busy} !== {1'b1, 12'd0, 4'b0001, 32'h41414141, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL first_char: got we=%b addr=%0d be=%b data=%h ready=%b busy=%b want 1 0 0001 41414141 0 1",
                  vram_we, vram_addr, vram_be, vram_wdata, char_ready, busy);
      end
      @(posedge clk);
      #1;
      total++;
      if ({vram_we, char_ready} !== 2'b01) begin
         bad++;
         $display("FAIL first_char_done: got we=%b ready=%b want we=0 ready=1", vram_we, char_ready);
      end
   endtask

   task automatic test_invert();
      send(8'h0D);
      send(8'h0A);
      send(8'h0A);
      for (int i = 0; i < 6; i++) send(8'h20 + 8'(i));
      total++;
      if ({cursor_col, cursor_row} !== {7'd6, 5'd2}) begin
         bad++;
         $display("FAIL invert_pos: got (%0d,%0d) want (6,2)", cursor_col, cursor_row);
      end
      send(8'hC1);
      total++;
      if ({vram_we, vram_addr, vram_be, vram_wdata, cursor_col, cursor_row} !== {1'b1, 12'd41, 4'b0100, 32'hC1C1C1C1, 7'd7, 5'd2}) begin
         bad++;
         $display("FAIL invert: got we=%b addr=%0d be=%b data=%h cur=(%0d,%0d) want 1 41 0100 c1c1c1c1 (7,2)",
                  vram_we, vram_addr, vram_be, vram_wdata, cursor_col, cursor_row);
      end
   endtask

   task automatic test_wrap();
      int s;
      send(8'h0D);
      for (int i = 0; i < 27; i++) send(8'h0A);
      for (int i = 0; i < 79; i++) send(8'h61 + 8'(i % 26));
      total++;
      if ({cursor_col, cursor_row} !== {7'd79, 5'd29}) begin
         bad++;
         $display("FAIL wrap_pos: got (%0d,%0d) want (79,29)", cursor_col, cursor_row);
      end
      send(8'h5A);
      total++;
      if ({vram_we, vram_addr, vram_be, vram_wdata, cursor_col, cursor_row} !== {1'b1, 12'd599, 4'b1000, 32'h5A5A5A5A, 7'd0, 5'd0}) begin
         bad++;
         $display("FAIL wrap_z: got we=%b addr=%0d be=%b data=%h cur=(%0d,%0d) want 1 599 1000 5a5a5a5a (0,0)",
                  vram_we, vram_addr, vram_be, vram_wdata, cursor_col, cursor_row);
      end
      for (int i = 0; i < 29; i++) send(8'h0A);
      s = nstrobe;
      send(8'h0A);
      @(negedge clk);
      total++;
      if ({cursor_col, cursor_row, 32'(nstrobe - s)} !== {7'd0, 5'd0, 32'd0}) begin
         bad++;
         $display("FAIL lf_wrap: got (%0d,%0d) strobes=%0d want (0,0) strobes=0", cursor_col, cursor_row, nstrobe - s);
      end
   endtask

   task automatic test_sequence();
      int s;
      int c0;
      int c1;
      int c2;
      s = nstrobe;
      send(8'h41);
      send(8'h42);
      send(8'h0D);
      c0 = cyc;
      send(8'h08);
      c1 = cyc;
      send(8'h0A);
      c2 = cyc;
      @(negedge clk);
      total++;
      if ({32'(c1 - c0), 32'(c2 - c1)} !== {32'd1, 32'd1}) begin
         bad++;
         $display("FAIL ctrl_back_to_back: got gaps %0d,%0d want 1,1", c1 - c0, c2 - c1);
      end
      total++;
      if (nstrobe - s !== 2) begin
         bad++;
         $display("FAIL seq_strobes: got %0d want 2", nstrobe - s);
      end
      s = nstrobe;
      send(8'h07);
      send(8'h7F);
      send(8'h87);
      @(negedge clk);
      total++;
      if ({32'(nstrobe - s), cursor_col, cursor_row} !== {32'd0, 7'd0, 5'd1}) begin
         bad++;
         $display("FAIL dropped: got strobes=%0d cur=(%0d,%0d) want 0 (0,1)", nstrobe - s, cursor_col, cursor_row);
      end
      send(8'h41);
      send(8'h41);
      send(8'h08);
   endtask

   task automatic test_clear();
      int s;
      int nbusy;
      int n;
      exp_t e;
      for (int i = 0; i < 600; i++) begin
         e.a = 12'(i);
         e.d = 32'h0;
         e.b = 4'hF;
         q.push_back(e);
      end
      s = nstrobe;
      send(8'h0C);
      char_valid = 1'b1;
      char_data = 8'h58;
      nbusy = 0;
      n = 0;
      @(negedge clk);
      while (busy && n < 1000) begin
         nbusy++;
         n++;
         @(negedge clk);
      end
      ecol = 0;
      erow = 0;
      total++;
      if ({32'(nbusy), 32'(nstrobe - s), cursor_col, cursor_row, char_ready} !== {32'd600, 32'd600, 7'd0, 5'd0, 1'b1}) begin
         bad++;
         $display("FAIL clear: got busy=%0d strobes=%0d cur=(%0d,%0d) ready=%b want 600 600 (0,0) 1",
                  nbusy, nstrobe - s, cursor_col, cursor_row, char_ready);
      end
      e.a = 12'd0;
      e.d = 32'h58585858;
      e.b = 4'b0001;
      q.push_back(e);
      ecol = 1;
      @(posedge clk);
      #1 char_valid = 1'b0;
      total++;
      if ({vram_we, vram_addr, vram_be, cursor_col, cursor_row} !== {1'b1, 12'd0, 4'b0001, 7'd1, 5'd0}) begin
         bad++;
         $display("FAIL held_x: got we=%b addr=%0d be=%b cur=(%0d,%0d) want 1 0 0001 (1,0)",
                  vram_we, vram_addr, vram_be, cursor_col, cursor_row);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      int s;
      for (int i = 0; i < 600; i++) q.push_back(exp_t'{a: 12'(i), d: 32'h0, b: 4'hF});
      send(8'h0C);
      n = 0;
      @(negedge clk);
      while (!(vram_we && vram_addr == 12'd300) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         total++;
         bad++;
         $display("FAIL mid_clear_timeout: got addr=%0d want 300", vram_addr);
      end
      #2 axi_aresetn = 1'b0;
      #1;
      total++;
      if ({vram_we, vram_addr, char_ready, busy, cursor_col, cursor_row} !== {1'b0, 12'd0, 1'b1, 1'b0, 7'd0, 5'd0}) begin
         bad++;
         $display("FAIL reset_async: got we=%b addr=%0d ready=%b busy=%b cur=(%0d,%0d) want 0 0 1 0 (0,0)",
                  vram_we, vram_addr, char_ready, busy, cursor_col, cursor_row);
      end
      q.delete();
      ecol = 0;
      erow = 0;
      repeat (3) @(negedge clk);
      axi_aresetn = 1'b1;
      s = nstrobe;
      repeat (20) @(negedge clk);
      total++;
      if ({32'(nstrobe - s), cursor_col, cursor_row, char_ready} !== {32'd0, 7'd0, 5'd0, 1'b1}) begin
         bad++;
         $display("FAIL after_reset: got strobes=%0d cur=(%0d,%0d) ready=%b want 0 (0,0) 1",
                  nstrobe - s, cursor_col, cursor_row, char_ready);
      end
   endtask

   initial begin
      test_reset();
      test_first_char();
      test_invert();
      test_wrap();
      test_sequence();
      test_clear();
      test_reset_mid_clear();
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
